tff_counter: RTL and testbench

TFF_COUNTER -- requirements
Module: tff_counter

---
 rtl/tff_counter.sv | 90 +++++++++
 tb/tb_tff_counter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tff_counter.sv
// Loadable T flip-flop register bank with modulo up/down count modes and a wrap pulse.
// Define TFF_COUNTER_SAT_EN to saturate at the count limits instead of wrapping.
module tff_counter #(
   parameter int              WIDTH   = 8,
   parameter longint unsigned MODULUS = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] t_vec,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

`ifdef TFF_COUNTER_SAT_EN
   localparam logic             C_WRAP_EN  = 1'b0;
   localparam logic [WIDTH-1:0] C_UP_TERM  = C_MAX;
   localparam logic [WIDTH-1:0] C_DN_TERM  = '0;
`else
   localparam logic             C_WRAP_EN  = 1'b1;
   localparam logic [WIDTH-1:0] C_UP_TERM  = '0;
   localparam logic [WIDTH-1:0] C_DN_TERM  = C_MAX;
`endif

   localparam logic [1:0] C_MODE_TOGGLE = 2'b00;
   localparam logic [1:0] C_MODE_UP     = 2'b01;
   localparam logic [1:0] C_MODE_DOWN   = 2'b10;

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;
   logic [WIDTH-1:0] w_next;
   logic             w_wrap;

   // Load beats counting, so a load on a terminal edge never raises a wrap.
   always_comb begin
      w_next = r_q;
      w_wrap = 1'b0;
      if (load) begin
         w_next = (load_val > C_MAX) ? C_MAX : load_val;
      end else if (en) begin
         case (mode)
            C_MODE_TOGGLE: w_next = r_q ^ t_vec;
            C_MODE_UP: begin
               if (r_q < C_MAX) begin
                  w_next = r_q + 1'b1;
               end else begin
                  w_next = C_UP_TERM;
                  w_wrap = 1'b1;
               end
            end
            C_MODE_DOWN: begin
               if (r_q == '0) begin
                  w_next = C_DN_TERM;
                  w_wrap = 1'b1;
               end else if (r_q > C_MAX) begin
                  // Out-of-range value left by toggling: clamp back without a wrap.
                  w_next = C_MAX;
               end else begin
                  w_next = r_q - 1'b1;
               end
            end
            default: w_next = r_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q    <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_q    <= w_next;
         r_wrap <= w_wrap & C_WRAP_EN;
      end
   end

   assign q     = r_q;
   assign q_bar = ~r_q;
   assign wrap  = r_wrap;
   assign tc    = en & ~load & (((mode == C_MODE_UP) & (r_q >= C_MAX)) |
                                ((mode == C_MODE_DOWN) & (r_q == '0)));

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter at WIDTH=4, MODULUS=10; follows TFF_COUNTER_SAT_EN if defined.
module tb_tff_counter;

   localparam int W = 4;

`ifdef TFF_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic [1:0]   mode;
   logic [W-1:0] t_vec;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] q;
   logic [W-1:0] q_bar;
   logic         tc;
   logic         wrap;

   int n_tests = 0;
   int n_fail  = 0;

   tff_counter #(.WIDTH(W), .MODULUS(10)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .t_vec(t_vec),
      .load(load), .load_val(load_val), .q(q), .q_bar(q_bar), .tc(tc), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; en = 1'b1; mode = 2'b01; load = 1'b1; load_val = 4'd5; t_vec = '0;
      step();
      n_tests++;
      if (q !== 4'd0) begin n_fail++; $display("FAIL reset_q: got %0d want 0", q); end
      n_tests++;
      if (q_bar !== 4'hF) begin n_fail++; $display("FAIL reset_qbar: got %h want f", q_bar); end
      n_tests++;
      if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap); end
   endtask

   task automatic test_count_up();
      logic [W-1:0] exp_q;
      logic         exp_w;
      reset = 1'b1; load = 1'b0; en = 1'b1; mode = 2'b01;
      for (int i = 1; i <= 12; i++) begin
         step();
         exp_q = SAT ? ((i > 9) ? 4'd9 : W'(i)) : W'(i % 10);
         exp_w = !SAT && (i == 10);
         n_tests++;
         if (q !== exp_q) begin n_fail++; $display("FAIL up_q[%0d]: got %0d want %0d", i, q, exp_q); end
         n_tests++;
         if (wrap !== exp_w) begin n_fail++; $display("FAIL up_wrap[%0d]: got %b want %b", i, wrap, exp_w); end
         n_tests++;
         if (tc !== (exp_q == 4'd9)) begin n_fail++; $display("FAIL up_tc[%0d]: got %b want %b", i, tc, exp_q == 4'd9); end
         n_tests++;
         if (q_bar !== ~exp_q) begin n_fail++; $display("FAIL up_qbar[%0d]: got %h want %h", i, q_bar, ~exp_q); end
      end
      en = 1'b0;
      exp_q = q;
      step();
      n_tests++;
      if (q !== exp_q || wrap !== 1'b0) begin
         n_fail++; $display("FAIL en_hold: got q=%0d wrap=%b want q=%0d wrap=0", q, wrap, exp_q);
      end
   endtask

   task automatic test_count_down();
      logic [W-1:0] seq_wrap [5];
      logic [W-1:0] seq_sat  [5];
      logic [W-1:0] exp_q;
      logic         exp_w;
      seq_wrap = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
      seq_sat  = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
      load = 1'b1; load_val = 4'd3; en = 1'b1; mode = 2'b10;
      step();
      n_tests++;
      if (q !== 4'd3 || wrap !== 1'b0) begin
         n_fail++; $display("FAIL dn_load: got q=%0d wrap=%b want q=3 wrap=0", q, wrap);
      end
      load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         exp_q = SAT ? seq_sat[i] : seq_wrap[i];
         exp_w = !SAT && (i == 3);
         n_tests++;
         if (q !== exp_q) begin n_fail++; $display("FAIL dn_q[%0d]: got %0d want %0d", i, q, exp_q); end
         n_tests++;
         if (wrap !== exp_w) begin n_fail++; $display("FAIL dn_wrap[%0d]: got %b want %b", i, wrap, exp_w); end
         n_tests++;
         if (tc !== (exp_q == 4'd0)) begin n_fail++; $display("FAIL dn_tc[%0d]: got %b want %b", i, tc, exp_q == 4'd0); end
      end
   endtask

   task automatic test_toggle();
      load = 1'b1; load_val = 4'd0; en = 1'b1; mode = 2'b00; t_vec = 4'b1011;
      step();
      load = 1'b0;
      step();
      n_tests++;
      if (q !== 4'b1011 || q_bar !== 4'b0100) begin
         n_fail++; $display("FAIL tog1: got q=%b q_bar=%b want 1011/0100", q, q_bar);
      end
      n_tests++;
      if (wrap !== 1'b0 || tc !== 1'b0) begin
         n_fail++; $display("FAIL tog1_flags: got wrap=%b tc=%b want 0/0", wrap, tc);
      end
      step();
      n_tests++;
      if (q !== 4'b0000 || q_bar !== 4'b1111 || wrap !== 1'b0) begin
         n_fail++; $display("FAIL tog2: got q=%b q_bar=%b wrap=%b want 0000/1111/0", q, q_bar, wrap);
      end
   endtask

   task automatic test_recover();
      logic [W-1:0] exp_q;
      logic         exp_w;
      // Reach 11 via load 0 then toggle, then recover down.
      load = 1'b1; load_val = 4'd0; en = 1'b1; mode = 2'b00; t_vec = 4'b1011;
      step();
      load = 1'b0;
      step();
      mode = 2'b10;
      #1;
      n_tests++;
      if (tc !== 1'b0) begin n_fail++; $display("FAIL oor_tc_dn: got %b want 0", tc); end
      step();
      n_tests++;
      if (q !== 4'd9 || wrap !== 1'b0) begin
         n_fail++; $display("FAIL oor_down: got q=%0d wrap=%b want q=9 wrap=0", q, wrap);
      end
      load = 1'b1; load_val = 4'd0; mode = 2'b00;
      step();
      load = 1'b0;
      step();
      mode = 2'b01;
      #1;
      n_tests++;
      if (tc !== 1'b1) begin n_fail++; $display("FAIL oor_tc_up: got %b want 1", tc); end
      step();
      exp_q = SAT ? 4'd9 : 4'd0;
      exp_w = !SAT;
      n_tests++;
      if (q !== exp_q || wrap !== exp_w) begin
         n_fail++; $display("FAIL oor_up: got q=%0d wrap=%b want q=%0d wrap=%b", q, wrap, exp_q, exp_w);
      end
   endtask

   task automatic test_load();
      load = 1'b1; load_val = 4'd12; en = 1'b0; mode = 2'b11;
      step();
      n_tests++;
      if (q !== 4'd9) begin n_fail++; $display("FAIL load_clamp: got %0d want 9", q); end
      load = 1'b1; load_val = 4'd4; en = 1'b1; mode = 2'b01;
      #1;
      n_tests++;
      if (tc !== 1'b0) begin n_fail++; $display("FAIL load_tc: got %b want 0", tc); end
      step();
      n_tests++;
      if (q !== 4'd4 || wrap !== 1'b0) begin
         n_fail++; $display("FAIL load_wins: got q=%0d wrap=%b want q=4 wrap=0", q, wrap);
      end
      load = 1'b0; mode = 2'b11;
      step();
      step();
      n_tests++;
      if (q !== 4'd4 || wrap !== 1'b0) begin
         n_fail++; $display("FAIL hold_mode: got q=%0d wrap=%b want q=4 wrap=0", q, wrap);
      end
   endtask

   task automatic test_reset_mid();
      load = 1'b1; load_val = 4'd9; en = 1'b1; mode = 2'b01;
      step();
      load = 1'b0; reset = 1'b0;
      step();
      n_tests++;
      if (q !== 4'd0 || wrap !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid: got q=%0d wrap=%b want q=0 wrap=0", q, wrap);
      end
      reset = 1'b1;
      step();
      n_tests++;
      if (q !== 4'd1 || wrap !== 1'b0) begin
         n_fail++; $display("FAIL reset_resume: got q=%0d wrap=%b want q=1 wrap=0", q, wrap);
      end
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; mode = 2'b11; t_vec = '0; load = 1'b0; load_val = '0;
      #1;
      test_reset();
      test_count_up();
      test_count_down();
      test_toggle();
      test_recover();
      test_load();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
